// File: rtl/pcs_64b66b_encoder_if.sv
// MII-word-in / 66-bit-block-out bundle for the 64b/66b PCS encoder.
// The master drives the MII word; the slave returns the encoded block and the error count.
interface pcs_64b66b_encoder_if #(
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     i_valid;
  logic [63:0]              i_mii_data;
  logic [7:0]               i_mii_ctrl;
  logic                     o_valid;
  logic [65:0]              o_block;
  logic [ERR_CNT_WIDTH-1:0] o_err_count;

  modport master (
    output i_valid, i_mii_data, i_mii_ctrl,
    input  o_valid, o_block, o_err_count
  );

  modport slave (
    input  i_valid, i_mii_data, i_mii_ctrl,
    output o_valid, o_block, o_err_count
  );
endinterface

// File: rtl/pcs_64b66b_encoder.sv
// 64b/66b PCS transmit encoder: classifies each MII word, runs the TX state machine and
// emits one 66-bit block per accepted word one cycle later. Optional scrambler: PCS_SCRAMBLER_EN.
module pcs_64b66b_encoder #(
  parameter int         DATA_WIDTH    = 64,
  parameter int         CTRL_WIDTH    = 8,
  parameter logic [7:0] IDLE_CODE     = 8'h07,
  parameter logic [7:0] START_CODE    = 8'hFB,
  parameter logic [7:0] TERM_CODE     = 8'hFD,
  parameter logic [7:0] ERROR_CODE    = 8'hFE,
  parameter int         ERR_CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 i_rst,
  pcs_64b66b_encoder_if.slave  bus
);
  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
  typedef enum logic [2:0] {W_C, W_S, W_D, W_T, W_E} word_t;

  localparam logic [DATA_WIDTH+1:0] IDLE_BLOCK  = {56'h0, 8'h1E, 2'b10};
  localparam logic [DATA_WIDTH+1:0] ERROR_BLOCK = {{8{7'h1E}}, 8'h1E, 2'b10};

  tx_state_t               r_state;
  logic                    r_valid;
  logic [DATA_WIDTH+1:0]   r_block;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  logic [7:0]            w_lane [CTRL_WIDTH];
  logic [CTRL_WIDTH-1:0] w_is_idle, w_is_err, w_t_ok;
  logic [55:0]           w_c_codes;

  // Per-lane decode; a terminate in lane gi needs ctrl set from gi upward and idles above it.
  for (genvar gi = 0; gi < CTRL_WIDTH; gi++) begin : g_lane
    localparam logic [7:0] HI    = 8'hFF << gi;
    localparam logic [7:0] ABOVE = 8'hFF << (gi + 1);
    assign w_lane[gi]    = bus.i_mii_data[8*gi +: 8];
    assign w_is_idle[gi] = (w_lane[gi] == IDLE_CODE);
    assign w_is_err[gi]  = (w_lane[gi] == ERROR_CODE);
    assign w_t_ok[gi]    = (bus.i_mii_ctrl == HI) && (w_lane[gi] == TERM_CODE) &&
                           ((w_is_idle & ABOVE) == ABOVE);
    assign w_c_codes[7*gi +: 7] = w_is_err[gi] ? 7'h1E : 7'h00;
  end

  logic       w_term_hit;
  logic [2:0] w_term_k;
  always_comb begin
    w_term_hit = 1'b0;
    w_term_k   = 3'd0;
    for (int k = 0; k < CTRL_WIDTH; k++) begin
      if (w_t_ok[k]) begin
        w_term_hit = 1'b1;
        w_term_k   = 3'(k);
      end
    end
  end

  word_t w_word;
  always_comb begin
    w_word = W_E;
    if (bus.i_mii_ctrl == 8'hFF && (&(w_is_idle | w_is_err)))
      w_word = W_C;
    else if (bus.i_mii_ctrl == 8'h01 && w_lane[0] == START_CODE)
      w_word = W_S;
    else if (bus.i_mii_ctrl == 8'h00)
      w_word = W_D;
    else if (w_term_hit)
      w_word = W_T;
  end

  tx_state_t w_next;
  always_comb begin
    w_next = TX_E;
    unique case (r_state)
      TX_INIT, TX_C, TX_T: begin
        if (w_word == W_C)      w_next = TX_C;
        else if (w_word == W_S) w_next = TX_D;
      end
      TX_D: begin
        if (w_word == W_D)      w_next = TX_D;
        else if (w_word == W_T) w_next = TX_T;
      end
      default: begin
        if (w_word == W_C)                        w_next = TX_C;
        else if (w_word == W_S || w_word == W_D)  w_next = TX_D;
        else if (w_word == W_T)                   w_next = TX_T;
      end
    endcase
  end

  logic [7:0]  w_t_type;
  logic [55:0] w_t_mask;
  always_comb begin
    case (w_term_k)
      3'd0:    w_t_type = 8'h87;
      3'd1:    w_t_type = 8'h99;
      3'd2:    w_t_type = 8'hAA;
      3'd3:    w_t_type = 8'hB4;
      3'd4:    w_t_type = 8'hCC;
      3'd5:    w_t_type = 8'hD2;
      3'd6:    w_t_type = 8'hE1;
      default: w_t_type = 8'hFF;
    endcase
    w_t_mask = (56'd1 << {w_term_k, 3'b000}) - 56'd1;
  end

  // Any move into TX_E replaces the word's own encoding with the error block.
  logic [DATA_WIDTH+1:0] w_block;
  always_comb begin
    w_block = ERROR_BLOCK;
    if (w_next != TX_E) begin
      case (w_word)
        W_C:     w_block = {w_c_codes, 8'h1E, 2'b10};
        W_S:     w_block = {bus.i_mii_data[63:8], 8'h78, 2'b10};
        W_D:     w_block = {bus.i_mii_data, 2'b01};
        W_T:     w_block = {bus.i_mii_data[55:0] & w_t_mask, w_t_type, 2'b10};
        default: w_block = ERROR_BLOCK;
      endcase
    end
  end

  logic [DATA_WIDTH+1:0] w_out;
`ifdef PCS_SCRAMBLER_EN
  // Self-synchronous 1 + x^39 + x^58; r_scr[0] is the most recent scrambled bit.
  logic [57:0] r_scr;
  logic [57:0] w_scr_next;
  logic [63:0] w_scr_pay;
  always_comb begin
    w_scr_next = r_scr;
    w_scr_pay  = '0;
    for (int i = 0; i < 64; i++) begin
      w_scr_pay[i] = w_block[i+2] ^ w_scr_next[38] ^ w_scr_next[57];
      w_scr_next   = {w_scr_next[56:0], w_scr_pay[i]};
    end
    w_out = {w_scr_pay, w_block[1:0]};
  end

  always_ff @(posedge clk) begin
    if (i_rst)            r_scr <= '1;
    else if (bus.i_valid) r_scr <= w_scr_next;
  end
`else
  assign w_out = w_block;
`endif

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state   <= TX_INIT;
      r_valid   <= 1'b0;
      r_block   <= IDLE_BLOCK;
      r_err_cnt <= '0;
    end else begin
      r_valid <= bus.i_valid;
      if (bus.i_valid) begin
        r_state <= w_next;
        r_block <= w_out;
        if (w_next == TX_E && r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign bus.o_valid     = r_valid;
  assign bus.o_block     = r_block;
  assign bus.o_err_count = r_err_cnt;
endmodule
